// File: rtl/dbbif_mem_slave.sv
// rtl/dbbif_mem_slave.sv - behavioural DBBIF memory slave with read queue, read latency and error counting
// Optional build macro: NVDLA_DBB_RAND_STALL_EN (LFSR-driven stalls on aw/w/ar readies)
module dbbif_mem_slave #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 64,
    parameter int ID_WIDTH       = 8,
    parameter int MEM_SIZE       = 1024,
    parameter int RD_LATENCY     = 4,
    parameter int RD_QUEUE_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      aw_awvalid,
    output logic                      aw_awready,
    input  logic [ID_WIDTH-1:0]       aw_awid,
    input  logic [3:0]                aw_awlen,
    input  logic [ADDR_WIDTH-1:0]     aw_awaddr,
    input  logic                      w_wvalid,
    output logic                      w_wready,
    input  logic [DATA_WIDTH-1:0]     w_wdata,
    input  logic [DATA_WIDTH/8-1:0]   w_wstrb,
    input  logic                      w_wlast,
    output logic                      b_bvalid,
    input  logic                      b_bready,
    output logic [ID_WIDTH-1:0]       b_bid,
    input  logic                      ar_arvalid,
    output logic                      ar_arready,
    input  logic [ID_WIDTH-1:0]       ar_arid,
    input  logic [3:0]                ar_arlen,
    input  logic [ADDR_WIDTH-1:0]     ar_araddr,
    output logic                      r_rvalid,
    input  logic                      r_rready,
    output logic [ID_WIDTH-1:0]       r_rid,
    output logic                      r_rlast,
    output logic [DATA_WIDTH-1:0]     r_rdata,
    output logic [15:0]               err_count
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BSH   = $clog2(BYTES);
    localparam int MW    = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam int QW    = (RD_QUEUE_DEPTH > 1) ? $clog2(RD_QUEUE_DEPTH) : 1;
    localparam int CW    = $clog2(RD_QUEUE_DEPTH + 1);
    localparam int LW    = $clog2(RD_LATENCY + 1);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_STREAM} r_state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] idx);
        return idx >= ADDR_WIDTH'(MEM_SIZE);
    endfunction

    // Ready stall mask: bit 0 aw, bit 1 w, bit 2 ar
    logic [2:0] stall;

`ifdef NVDLA_DBB_RAND_STALL_EN
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;

    assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    // The readies are registered, so they are gated with the value the LFSR holds in their own cycle
    assign stall = lfsr_next[2:0];

    // Free-running stall LFSR
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= lfsr_next;
        end
    end
`else
    assign stall = 3'b000;
`endif

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    w_state_t              w_state;
    w_state_t              w_state_next;
    logic [3:0]            w_len;
    logic [3:0]            w_beat;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  b_hs;
    logic                  w_final;
    logic                  w_oor;
    logic                  wlast_err;

    assign aw_hs     = aw_awvalid && aw_awready;
    assign w_hs      = w_wvalid && w_wready;
    assign b_hs      = b_bvalid && b_bready;
    assign w_final   = (w_beat == w_len);
    assign w_oor     = out_of_range(w_idx);
    assign wlast_err = (w_wlast != w_final);

    // Write FSM next state; the burst ends on the beat count, wlast only feeds the error counter
    always_comb begin
        w_state_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_state_next = W_DATA;
            W_DATA:  if (w_hs && w_final) w_state_next = W_RESP;
            W_RESP:  if (b_hs) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    // Write FSM state, registered handshake outputs and burst bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state    <= W_IDLE;
            aw_awready <= 1'b0;
            w_wready   <= 1'b0;
            b_bvalid   <= 1'b0;
            b_bid      <= '0;
            w_len      <= '0;
            w_beat     <= '0;
            w_idx      <= '0;
        end else begin
            w_state    <= w_state_next;
            aw_awready <= (w_state_next == W_IDLE) && !stall[0];
            w_wready   <= (w_state_next == W_DATA) && !stall[1];
            b_bvalid   <= (w_state_next == W_RESP);
            if (aw_hs) begin
                b_bid  <= aw_awid;
                w_len  <= aw_awlen;
                w_idx  <= aw_awaddr >> BSH;
                w_beat <= '0;
            end else if (w_hs) begin
                w_idx  <= w_idx + ADDR_WIDTH'(1);
                w_beat <= w_beat + 4'd1;
            end
        end
    end

    // Byte-strobed memory write; contents survive reset, out-of-range beats are dropped
    always_ff @(posedge clk) begin
        if (!rst && w_hs && !w_oor) begin
            for (int b = 0; b < BYTES; b++) begin
                if (w_wstrb[b]) begin
                    mem[w_idx[MW-1:0]][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read queue
    // ------------------------------------------------------------------
    logic [ID_WIDTH-1:0]   q_id  [RD_QUEUE_DEPTH];
    logic [3:0]            q_len [RD_QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] q_idx [RD_QUEUE_DEPTH];
    logic [QW-1:0]         q_wr;
    logic [QW-1:0]         q_rd;
    logic [CW-1:0]         q_count;
    logic [CW-1:0]         q_count_next;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  q_pop;

    assign ar_hs        = ar_arvalid && ar_arready;
    assign r_hs         = r_rvalid && r_rready;
    assign q_pop        = r_hs && r_rlast;
    assign q_count_next = q_count + CW'(ar_hs) - CW'(q_pop);

    // Queue payload storage
    always_ff @(posedge clk) begin
        if (ar_hs) begin
            q_id[q_wr]  <= ar_arid;
            q_len[q_wr] <= ar_arlen;
            q_idx[q_wr] <= ar_araddr >> BSH;
        end
    end

    // Queue pointers and occupancy; arready reflects the occupancy after this cycle's push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            q_wr       <= '0;
            q_rd       <= '0;
            q_count    <= '0;
            ar_arready <= 1'b0;
        end else begin
            q_count    <= q_count_next;
            ar_arready <= (q_count_next != CW'(RD_QUEUE_DEPTH)) && !stall[2];
            if (ar_hs) begin
                q_wr <= (q_wr == QW'(RD_QUEUE_DEPTH - 1)) ? '0 : q_wr + QW'(1);
            end
            if (q_pop) begin
                q_rd <= (q_rd == QW'(RD_QUEUE_DEPTH - 1)) ? '0 : q_rd + QW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Read streaming
    // ------------------------------------------------------------------
    r_state_t              r_state;
    r_state_t              r_state_next;
    logic [LW-1:0]         r_lat;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic [3:0]            rd_beat;
    logic                  r_present;
    logic [ADDR_WIDTH-1:0] r_load_idx;
    logic [3:0]            r_load_beat;
    logic                  r_oor;

    assign r_oor = out_of_range(r_load_idx);

    // Read FSM next state and the index/beat of the beat about to be presented
    always_comb begin
        r_state_next = r_state;
        r_present    = 1'b0;
        r_load_idx   = rd_idx + ADDR_WIDTH'(1);
        r_load_beat  = rd_beat + 4'd1;
        case (r_state)
            R_IDLE: begin
                if (q_count != '0 || ar_hs) r_state_next = R_WAIT;
            end
            R_WAIT: begin
                if (r_lat == '0) begin
                    r_state_next = R_STREAM;
                    r_present    = 1'b1;
                    r_load_idx   = q_idx[q_rd];
                    r_load_beat  = 4'd0;
                end
            end
            R_STREAM: begin
                if (r_hs) begin
                    if (r_rlast) begin
                        r_state_next = (q_count_next != '0) ? R_WAIT : R_IDLE;
                    end else begin
                        r_present = 1'b1;
                    end
                end
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    // Read FSM state, latency countdown and registered R channel; a stalled beat simply holds
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= R_IDLE;
            r_lat    <= '0;
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            r_rid    <= '0;
            r_rdata  <= '0;
            rd_idx   <= '0;
            rd_beat  <= '0;
        end else begin
            r_state <= r_state_next;
            // Entering WAIT counts the cycle of entry, hence RD_LATENCY-1
            if (r_state_next == R_WAIT && r_state != R_WAIT) begin
                r_lat <= LW'(RD_LATENCY - 1);
            end else if (r_state == R_WAIT && r_lat != '0) begin
                r_lat <= r_lat - LW'(1);
            end
            if (r_present) begin
                r_rvalid <= 1'b1;
                r_rlast  <= (r_load_beat == q_len[q_rd]);
                r_rid    <= q_id[q_rd];
                r_rdata  <= r_oor ? '0 : mem[r_load_idx[MW-1:0]];
                rd_idx   <= r_load_idx;
                rd_beat  <= r_load_beat;
            end else if (q_pop) begin
                r_rvalid <= 1'b0;
                r_rlast  <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Error counter
    // ------------------------------------------------------------------
    logic [1:0]  err_inc;
    logic [16:0] err_sum;

    assign err_inc = {1'b0, w_hs && w_oor} + {1'b0, w_hs && wlast_err} + {1'b0, r_present && r_oor};
    assign err_sum = {1'b0, err_count} + 17'(err_inc);

    // Saturating count of out-of-range beats and wlast mismatches
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else begin
            err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

endmodule

// File: tb/tb_dbbif_mem_slave.sv
// tb/tb_dbbif_mem_slave.sv - directed self-checking bench for dbbif_mem_slave
module tb_dbbif_mem_slave;

    localparam int RD_LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        aw_awvalid = 1'b0;
    logic        aw_awready;
    logic [7:0]  aw_awid = '0;
    logic [3:0]  aw_awlen = '0;
    logic [31:0] aw_awaddr = '0;
    logic        w_wvalid = 1'b0;
    logic        w_wready;
    logic [63:0] w_wdata = '0;
    logic [7:0]  w_wstrb = '0;
    logic        w_wlast = 1'b0;
    logic        b_bvalid;
    logic        b_bready = 1'b0;
    logic [7:0]  b_bid;
    logic        ar_arvalid = 1'b0;
    logic        ar_arready;
    logic [7:0]  ar_arid = '0;
    logic [3:0]  ar_arlen = '0;
    logic [31:0] ar_araddr = '0;
    logic        r_rvalid;
    logic        r_rready = 1'b0;
    logic [7:0]  r_rid;
    logic        r_rlast;
    logic [63:0] r_rdata;
    logic [15:0] err_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] wbuf     [16];
    logic [63:0] got_data [16];
    logic [7:0]  got_id   [16];
    logic        got_last [16];
    int          got_n;

    dbbif_mem_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(8), .MEM_SIZE(1024),
        .RD_LATENCY(RD_LAT), .RD_QUEUE_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .aw_awvalid(aw_awvalid), .aw_awready(aw_awready), .aw_awid(aw_awid),
        .aw_awlen(aw_awlen), .aw_awaddr(aw_awaddr),
        .w_wvalid(w_wvalid), .w_wready(w_wready), .w_wdata(w_wdata),
        .w_wstrb(w_wstrb), .w_wlast(w_wlast),
        .b_bvalid(b_bvalid), .b_bready(b_bready), .b_bid(b_bid),
        .ar_arvalid(ar_arvalid), .ar_arready(ar_arready), .ar_arid(ar_arid),
        .ar_arlen(ar_arlen), .ar_araddr(ar_araddr),
        .r_rvalid(r_rvalid), .r_rready(r_rready), .r_rid(r_rid),
        .r_rlast(r_rlast), .r_rdata(r_rdata), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [7:0] strb, input bit early_last);
        int n;
        aw_awvalid = 1'b1; aw_awid = id; aw_awaddr = addr; aw_awlen = len;
        n = 0;
        while (!aw_awready && n < 50) begin @(negedge clk); n++; end
        check("aw_handshake", 64'(n < 50), 64'd1);
        @(negedge clk);
        aw_awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            w_wvalid = 1'b1;
            w_wdata  = wbuf[b];
            w_wstrb  = strb;
            w_wlast  = early_last ? 1'b1 : (b == int'(len));
            n = 0;
            while (!w_wready && n < 50) begin @(negedge clk); n++; end
            check("w_handshake", 64'(n < 50), 64'd1);
            @(negedge clk);
        end
        w_wvalid = 1'b0; w_wlast = 1'b0;
        b_bready = 1'b1;
        n = 0;
        while (!b_bvalid && n < 50) begin @(negedge clk); n++; end
        check("b_valid", 64'(b_bvalid), 64'd1);
        check("b_bid", 64'(b_bid), 64'(id));
        @(negedge clk);
        b_bready = 1'b0;
        check("b_once", 64'(b_bvalid), 64'd0);
    endtask

    task automatic send_ar(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
        int n;
        ar_arvalid = 1'b1; ar_arid = id; ar_araddr = addr; ar_arlen = len;
        n = 0;
        while (!ar_arready && n < 100) begin @(negedge clk); n++; end
        check("ar_handshake", 64'(n < 100), 64'd1);
        @(negedge clk);
        ar_arvalid = 1'b0;
    endtask

    task automatic collect(input int nbeats, input int stall_beat);
        int guard;
        logic [63:0] d0;
        logic [7:0]  i0;
        logic        l0;
        got_n = 0;
        guard = 0;
        while (got_n < nbeats && guard < 300) begin
            r_rready = 1'b1;
            if (r_rvalid) begin
                if (got_n == stall_beat) begin
                    r_rready = 1'b0;
                    d0 = r_rdata; i0 = r_rid; l0 = r_rlast;
                    repeat (3) begin
                        @(negedge clk);
                        check("hold_rvalid", 64'(r_rvalid), 64'd1);
                        check("hold_rdata", r_rdata, d0);
                        check("hold_rid", 64'(r_rid), 64'(i0));
                        check("hold_rlast", 64'(r_rlast), 64'(l0));
                    end
                    r_rready = 1'b1;
                end
                got_data[got_n] = r_rdata;
                got_id[got_n]   = r_rid;
                got_last[got_n] = r_rlast;
                got_n++;
            end
            @(negedge clk);
            guard++;
        end
        r_rready = 1'b0;
        check("r_beats", 64'(got_n), 64'(nbeats));
        check("r_no_extra", 64'(r_rvalid), 64'd0);
    endtask

    task automatic read_burst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                              input int stall_beat);
        int cyc;
        send_ar(id, addr, len);
        cyc = 0;
        while (!r_rvalid && cyc < 50) begin @(negedge clk); cyc++; end
        check("rd_latency", 64'(cyc), 64'(RD_LAT));
        collect(int'(len) + 1, stall_beat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_awready", 64'(aw_awready), 64'd0);
        check("rst_arready", 64'(ar_arready), 64'd0);
        check("rst_wready", 64'(w_wready), 64'd0);
        check("rst_bvalid", 64'(b_bvalid), 64'd0);
        check("rst_rvalid", 64'(r_rvalid), 64'd0);
        check("rst_rdata", r_rdata, 64'd0);
        check("rst_err", 64'(err_count), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_awready", 64'(aw_awready), 64'd1);
        check("post_rst_arready", 64'(ar_arready), 64'd1);

        // Four-beat write then read back
        for (int i = 0; i < 4; i++) wbuf[i] = 64'(8'h11 * (i + 1));
        do_write(8'h5A, 32'h100, 4'd3, 8'hFF, 1'b0);
        read_burst(8'h3C, 32'h100, 4'd3, -1);
        for (int i = 0; i < 4; i++) begin
            check("burst_rdata", got_data[i], 64'(8'h11 * (i + 1)));
            check("burst_rid", 64'(got_id[i]), 64'h3C);
            check("burst_rlast", 64'(got_last[i]), 64'(i == 3));
        end

        // Byte strobes
        wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        do_write(8'h01, 32'h200, 4'd0, 8'hFF, 1'b0);
        wbuf[0] = 64'h0;
        do_write(8'h02, 32'h200, 4'd0, 8'h0F, 1'b0);
        read_burst(8'h03, 32'h200, 4'd0, -1);
        check("strobe_rdata", got_data[0], 64'hFFFF_FFFF_0000_0000);

        // Queue fill: four pushes, fifth blocked until a pop
        for (int i = 1; i <= 4; i++) send_ar(8'(i), 32'h100, 4'd0);
        ar_arvalid = 1'b1; ar_arid = 8'd5; ar_araddr = 32'h100; ar_arlen = 4'd0;
        check("q_full_arready", 64'(ar_arready), 64'd0);
        repeat (3) @(negedge clk);
        check("q_full_hold", 64'(ar_arready), 64'd0);
        fork
            begin
                int n = 0;
                while (!ar_arready && n < 100) begin @(negedge clk); n++; end
                check("ar5_handshake", 64'(n < 100), 64'd1);
                @(negedge clk);
                ar_arvalid = 1'b0;
            end
            collect(5, -1);
        join
        for (int i = 0; i < 5; i++) check("q_order_rid", 64'(got_id[i]), 64'(i + 1));

        // Mid-burst rready stall
        read_burst(8'h44, 32'h100, 4'd3, 1);
        for (int i = 0; i < 4; i++) begin
            check("stall_rdata", got_data[i], 64'(8'h11 * (i + 1)));
            check("stall_rlast", 64'(got_last[i]), 64'(i == 3));
        end

        // Out-of-range read, early wlast, out-of-range write
        read_burst(8'h09, 32'h2000, 4'd0, -1);
        check("oor_rdata", got_data[0], 64'd0);
        check("err_after_oor_read", 64'(err_count), 64'd1);
        wbuf[0] = 64'h1234; wbuf[1] = 64'h5678;
        do_write(8'h0A, 32'h300, 4'd1, 8'h00, 1'b1);
        check("err_after_early_wlast", 64'(err_count), 64'd2);
        wbuf[0] = 64'hDEAD_BEEF_0000_0001;
        do_write(8'h0B, 32'h0, 4'd0, 8'hFF, 1'b0);
        wbuf[0] = 64'h5555_5555_5555_5555;
        do_write(8'h0C, 32'h2000, 4'd0, 8'hFF, 1'b0);
        check("err_after_oor_write", 64'(err_count), 64'd3);
        read_burst(8'h0D, 32'h0, 4'd0, -1);
        check("oor_write_dropped", got_data[0], 64'hDEAD_BEEF_0000_0001);

        // Reset during a read burst
        send_ar(8'h77, 32'h100, 4'd15);
        begin
            int n = 0;
            while (!r_rvalid && n < 50) begin @(negedge clk); n++; end
            check("pre_rst_rvalid", 64'(r_rvalid), 64'd1);
        end
        r_rready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        r_rready = 1'b0;
        @(negedge clk);
        check("mid_rst_rvalid", 64'(r_rvalid), 64'd0);
        check("mid_rst_err", 64'(err_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("after_rst_arready", 64'(ar_arready), 64'd1);
        read_burst(8'h78, 32'h100, 4'd0, -1);
        check("retained_rdata", got_data[0], 64'h11);
        read_burst(8'h79, 32'h200, 4'd0, -1);
        check("retained_strobe", got_data[0], 64'hFFFF_FFFF_0000_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dbbif_mem_slave.md
Name: dbbif_mem_slave
Overview:
Parametrised successor to the single-outstanding DBBIF DRAM model. It is a behavioural memory slave on the NVDLA core DBBIF (AXI-like), with generic data and ID widths, a queue of outstanding reads, a programmable read latency, byte-strobed bursts and out-of-range error counting. It sits beside NV_nvdla in the top-level bench and terminates all core2dbb traffic.
Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 64, data bus width; power of 2, range 32..512; BYTES = DATA_WIDTH/8
ID_WIDTH, 8, width of the AXI ID fields
MEM_SIZE, 1024, memory depth in DATA_WIDTH words
RD_LATENCY, 4, cycles (≥1) from a read reaching queue head to its first rvalid
RD_QUEUE_DEPTH, 4, maximum accepted-but-unfinished reads (power of 2)
Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
aw_awvalid  in  1  write address valid
aw_awready  out  1  write address ready
aw_awid  in  ID_WIDTH  write ID
aw_awlen  in  4  beats minus 1
aw_awaddr  in  ADDR_WIDTH  byte address
w_wvalid  in  1  write data valid
w_wready  out  1  write data ready
w_wdata  in  DATA_WIDTH  write data
w_wstrb  in  BYTES  byte enables
w_wlast  in  1  last write beat
b_bvalid  out  1  write response valid
b_bready  in  1  write response ready
b_bid  out  ID_WIDTH  response ID
ar_arvalid  in  1  read address valid
ar_arready  out  1  read address ready
ar_arid  in  ID_WIDTH  read ID
ar_arlen  in  4  beats minus 1
ar_araddr  in  ADDR_WIDTH  byte address
r_rvalid  out  1  read data valid
r_rready  in  1  read data ready
r_rid  out  ID_WIDTH  read ID
r_rlast  out  1  last read beat
r_rdata  out  DATA_WIDTH  read data
err_count  out  16  saturating error counter
Behaviour:
- One clock, clk. Synchronous active-high reset rst. All outputs are registered.
- Reset values: every ready, bvalid, rvalid, rlast, bid, rid, rdata and err_count is 0. Reset clears both FSMs, the read queue and the counters. Memory contents are retained. A reset mid-burst abandons the burst with no response.
- Addressing: word index = addr >> log2(BYTES), then incremented by 1 per beat. Low address bits are ignored.
- A beat is out of range when its word index ≥ MEM_SIZE. On such a beat, a write is dropped, a read returns 0, and err_count increments by 1 (saturating at 0xFFFF).
- Write FSM, IDLE→DATA→RESP→IDLE:
  - IDLE: aw_awready=1. On an aw handshake, latch id, len and index, then go to DATA.
  - DATA: w_wready=1. On each w handshake, write only the bytes whose wstrb bit is 1, then advance index and beat count.
  - The final beat is beat count == len. Leave DATA on that beat regardless of wlast. If wlast != (beat == len) on any beat, err_count increments.
  - RESP: b_bvalid=1 and b_bid = latched id. On b_bready, go to IDLE.
  - Throughput is one beat per cycle. aw_awready is 0 outside IDLE.
- Read queue: ar_arready = !full. An ar handshake pushes {id, len, index}.
  - Entries are served strictly in order.
  - When an entry becomes head, a latency counter loads RD_LATENCY and decrements each cycle. At 0, streaming starts.
  - Streaming: rvalid=1, rid = entry id, rdata = mem[index]. rlast=1 on beat len.
  - While rvalid && !rready, rvalid, rdata, rid and rlast hold stable.
  - On a handshake, the next beat is presented the following cycle (back-to-back beats). After the rlast handshake, pop the entry; the next head begins its own latency count the following cycle.
- Simultaneous push and pop are allowed when full: the pop frees a slot, but arready is registered, so a new push is not accepted until the next cycle.
- Read and write to the same word in the same cycle: the read returns the old data (read-before-write).
- Bursts are 1..16 beats. Word index wrap past the address width is not supported; out-of-range checking covers it.
Optional Feature:
NVDLA_DBB_RAND_STALL_EN:
- Defined: a 16-bit LFSR (seed 0xACE1, reset on rst, advances every cycle) gates aw_awready, w_wready and ar_arready. Each ready is forced to 0 when its LFSR bit (bits 0, 1, 2 respectively) is 1. Handshake rules and data integrity are unchanged.
- Undefined: no gating; the readies behave exactly as described above.
Test Plan:
- Write 4 beats at 0x100 with wstrb=0xFF, data 0x11..0x44, then read len=3 at 0x100 → bvalid once with matching bid; first rvalid exactly RD_LATENCY cycles after the ar handshake; rdata 0x11,0x22,0x33,0x44; rlast on beat 4.
- Write 0xFFFF_FFFF_FFFF_FFFF, then write 0 with wstrb=0x0F at the same address, then read → rdata 0xFFFF_FFFF_0000_0000.
- Issue 5 back-to-back ARs (ids 1..5, len 0) with RD_QUEUE_DEPTH=4 and rready=0 → arready drops after 4 pushes; on releasing rready, rids arrive in order 1..5.
- Hold rready=0 for 3 cycles mid-burst → rdata, rid and rlast stay stable; no beat is lost or duplicated.
- Read at word index MEM_SIZE, and send a burst with early wlast → rdata 0, err_count = 1 then 2; memory is unchanged.
- Assert rst during a read burst → rvalid=0 on the next cycle; arready=1 the cycle after rst deasserts; previously written data is still readable.
